// File: rtl/dbg_pkg.sv
// Shared definitions for the state dump engine: FSM states, channel indices, default map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    READ,
    SEND,
    DONE
  } dump_state_t;

  // Channel order on the debug read bus of single_cycle_mips.
  localparam int CH_REGS = 0;
  localparam int CH_DMEM = 1;
  localparam int CH_IMEM = 2;

  // Last address per channel, channel 0 in the least significant slice:
  // 32-entry-capable register file walked over 16 entries, 1 Ki word dmem and imem.
  localparam logic [29:0] DEF_CH_LAST = {10'd1023, 10'd1023, 10'd15};

  // Channel index width; never zero so a single-channel build still has a field.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/state_dump_engine_if.sv
// Dump output stream: one word per transfer, tagged with channel, address and last flag.
// Latency: n/a (wires only).
// Backpressure: master holds valid/data/ch/addr/last stable until valid && ready.
interface state_dump_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 2
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (output valid, data, ch, addr, last, input ready);
  modport slave  (input valid, data, ch, addr, last, output ready);

endinterface

// File: rtl/dump_ch_select.sv
// Priority search: lowest enabled channel index >= from; none=1 when no such channel.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: en (latched channel enables), from (start index, one bit wider so NUM_CH
//        itself means "past the end"), idx (found channel), none (nothing found).
module dump_ch_select #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] en,
  input  logic [CH_W:0]     from,
  output logic [CH_W-1:0]   idx,
  output logic              none
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && ((CH_W + 1)'(i) >= from)) begin
        idx  = CH_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/state_dump_engine.sv
// Freezes the MIPS core on a trigger and streams every word of each enabled channel out.
// Latency: one word per 2 cycles (RD_LAT=0) or 3 cycles (RD_LAT=1) at full rate.
// Backpressure: output held while out.valid && !out.ready; the walk stalls, nothing dropped.
// Ports: clock/reset (sync, active-high); start, trig_cyc, ch_en trigger a dump;
//        freeze holds the core; rd_addr/rd_data are the shared debug read bus;
//        out is the tagged word stream; done/ack close the dump; cycles counts run time.
module state_dump_engine
  import dbg_pkg::*;
#(
  parameter int                       DATA_W  = 32,
  parameter int                       ADDR_W  = 10,
  parameter int                       NUM_CH  = 3,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_LAST = DEF_CH_LAST,
  parameter int                       RD_LAT  = 0,
  parameter int                       CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         trig_cyc,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     freeze,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_CH*DATA_W-1:0] rd_data,
  state_dump_engine_if.master      out,
  output logic                     done,
  input  logic                     ack,
  output logic [CNT_W-1:0]         cycles
);

  localparam int CH_W = ch_w(NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_last_chk
    if (int'(CH_LAST[g*ADDR_W +: ADDR_W]) > (2**ADDR_W) - 1) begin : g_bad
      $error("state_dump_engine: CH_LAST of a channel exceeds the address range");
    end
  end
  if (RD_LAT != 0 && RD_LAT != 1) begin : g_lat_chk
    $error("state_dump_engine: RD_LAT must be 0 or 1");
  end

  dump_state_t         state_q, state_d;
  logic [NUM_CH-1:0]   en_q;
  logic [CH_W-1:0]     ch_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                wait_q;
  logic [CNT_W-1:0]    cycles_q;
  logic                freeze_q, done_q;
  logic                valid_q, last_q;
  logic [DATA_W-1:0]   data_q;
  logic [CH_W-1:0]     och_q;
  logic [ADDR_W-1:0]   oaddr_q;

  logic                trigger;
  logic [CH_W:0]       sel_from;
  logic [CH_W-1:0]     sel_idx;
  logic                sel_none;
  logic [ADDR_W-1:0]   cur_last;
  logic                at_end;
  logic [DATA_W-1:0]   rd_word;
  logic                read_go;
  logic                accept;

  assign trigger  = start || ((trig_cyc != '0) && (cycles_q == trig_cyc));
  // In SEL the search includes the current channel; elsewhere it looks past it,
  // which tells READ whether this is the final channel and SEND where to go next.
  assign sel_from = (state_q == SEL) ? {1'b0, ch_q} : ({1'b0, ch_q} + 1'b1);
  assign cur_last = CH_LAST[ch_q*ADDR_W +: ADDR_W];
  assign at_end   = (rd_addr_q == cur_last);
  assign rd_word  = rd_data[ch_q*DATA_W +: DATA_W];
  // A registered channel needs one extra cycle after rd_addr settles.
  assign read_go  = (RD_LAT == 0) || wait_q;
  assign accept   = valid_q && out.ready;

  dump_ch_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_sel (
    .en   (en_q),
    .from (sel_from),
    .idx  (sel_idx),
    .none (sel_none)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trigger) state_d = (ch_en == '0) ? DONE : SEL;
      SEL:  state_d = READ;
      READ: if (read_go) state_d = SEND;
      SEND: begin
        if (accept) begin
          if (!at_end)       state_d = READ;
          else if (sel_none) state_d = DONE;
          else               state_d = SEL;
        end
      end
      DONE: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q      <= '0;
      ch_q      <= '0;
      rd_addr_q <= '0;
      wait_q    <= 1'b0;
      cycles_q  <= '0;
      freeze_q  <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      och_q     <= '0;
      oaddr_q   <= '0;
    end else begin
      freeze_q <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      // Only a running core counts; the trigger cycle itself is already frozen time.
      if (state_q == IDLE && !trigger && cycles_q != '1) cycles_q <= cycles_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            en_q <= ch_en;
            ch_q <= CH_W'(CH_REGS);
          end
        end
        SEL: begin
          ch_q      <= sel_idx;
          rd_addr_q <= '0;
          wait_q    <= 1'b0;
        end
        READ: begin
          if (!read_go) begin
            wait_q <= 1'b1;
          end else begin
            wait_q  <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= rd_word;
            och_q   <= ch_q;
            oaddr_q <= rd_addr_q;
            last_q  <= at_end && sel_none;
          end
        end
        SEND: begin
          if (accept) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (!at_end)        rd_addr_q <= rd_addr_q + 1'b1;
            else if (!sel_none) ch_q      <= sel_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign freeze    = freeze_q;
  assign done      = done_q;
  assign cycles    = cycles_q;
  assign rd_addr   = rd_addr_q;
  assign out.valid = valid_q;
  assign out.data  = data_q;
  assign out.ch    = och_q;
  assign out.addr  = oaddr_q;
  assign out.last  = last_q;

endmodule
